uc_mc: RTL

Multicycle control unit for the 6-bit-opcode datapath. It sequences each instruction through FETCH/EXEC. It stretches IN/OUT instructions with a ready/acknowledge port handshake and a timeout, and tracks return-stack depth for JAL/RET with overflow and underflow traps. Z is sampled from a registered flag. The block sits between the instruction register and the datapath enables (PC mux, register file, ALU, port, return stack).

---
 rtl/uc_mc_if.sv | 34 +++
 rtl/uc_mc.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/uc_mc_if.sv
// rtl/uc_mc_if.sv - opcode/flag/handshake inputs and datapath enables of the multicycle control unit
interface uc_mc_if #(
  parameter int ALU_W   = 3,
  parameter int DEPTH_W = 4
);
  logic [5:0]         opcode;
  logic               z;
  logic               io_ack;
  logic               ir_load;
  logic               pc_en;
  logic               s_inc;
  logic [1:0]         sel_inputs;
  logic               we3;
  logic               wez;
  logic               we_port;
  logic               we_stack;
  logic               s_jret;
  logic [ALU_W-1:0]   op_alu;
  logic               io_req;
  logic [DEPTH_W-1:0] depth;
  logic               trap;

  modport master (
    output opcode, z, io_ack,
    input  ir_load, pc_en, s_inc, sel_inputs, we3, wez, we_port, we_stack,
           s_jret, op_alu, io_req, depth, trap
  );

  modport slave (
    input  opcode, z, io_ack,
    output ir_load, pc_en, s_inc, sel_inputs, we3, wez, we_port, we_stack,
           s_jret, op_alu, io_req, depth, trap
  );
endinterface

// File: rtl/uc_mc.sv
// rtl/uc_mc.sv - FETCH/EXEC sequencer with IO handshake timeout and return-stack depth traps
module uc_mc #(
  parameter int STACK_DEPTH = 8,
  parameter int IO_TIMEOUT  = 16,
  parameter int ALU_W       = 3
) (
  input logic   clk,
  input logic   reset,
  uc_mc_if.slave bus
);
  localparam int DEPTH_W = $clog2(STACK_DEPTH + 1);
  localparam int CNT_W   = (IO_TIMEOUT > 1) ? $clog2(IO_TIMEOUT) : 1;
  localparam logic [DEPTH_W-1:0] DEPTH_MAX = DEPTH_W'(STACK_DEPTH);
  localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(IO_TIMEOUT - 1);

  typedef enum logic [1:0] {FETCH, EXEC, IO_WAIT, HALT} state_t;

  state_t             state, state_next;
  logic [DEPTH_W-1:0] depth_q, depth_next;
  logic [CNT_W-1:0]   cnt_q, cnt_next;
  logic [5:0]         op;

  logic             ir_load, pc_en, s_inc, we3, wez, we_port, we_stack, s_jret;
  logic             io_req, trap;
  logic [1:0]       sel_inputs;
  logic [ALU_W-1:0] op_alu;

  assign op = bus.opcode;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= FETCH;
      depth_q <= '0;
      cnt_q   <= '0;
    end else begin
      state   <= state_next;
      depth_q <= depth_next;
      cnt_q   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    depth_next = depth_q;
    cnt_next   = cnt_q;
    ir_load    = 1'b0;
    pc_en      = 1'b0;
    s_inc      = 1'b0;
    sel_inputs = 2'b00;
    we3        = 1'b0;
    wez        = 1'b0;
    we_port    = 1'b0;
    we_stack   = 1'b0;
    s_jret     = 1'b0;
    op_alu     = '0;
    io_req     = 1'b0;
    trap       = 1'b0;

    case (state)
      FETCH: begin
        ir_load    = 1'b1;
        state_next = EXEC;
      end

      EXEC: begin
        op_alu     = op[ALU_W+1:2];
        pc_en      = 1'b1;
        state_next = FETCH;
        casez (op)
          6'b0?????: begin
            s_inc = 1'b1;
            we3   = 1'b1;
            wez   = 1'b1;
          end
          6'b1000??: begin
            s_inc      = 1'b1;
            sel_inputs = 2'b11;
            we3        = 1'b1;
          end
          // op[0] selects branch-on-nonzero; the jump is taken when z differs from it
          6'b10010?: s_inc = ~(bus.z ^ op[0]);
          6'b100110: s_inc = 1'b0;
          6'b100111, 6'b101000: begin
            pc_en      = 1'b0;
            io_req     = 1'b1;
            cnt_next   = '0;
            state_next = IO_WAIT;
          end
          6'b101001: begin
            if (depth_q < DEPTH_MAX) begin
              we_stack   = 1'b1;
              depth_next = depth_q + 1'b1;
            end else begin
              pc_en      = 1'b0;
              state_next = HALT;
            end
          end
          6'b101010: begin
            if (depth_q != '0) begin
              s_jret     = 1'b1;
              depth_next = depth_q - 1'b1;
            end else begin
              pc_en      = 1'b0;
              state_next = HALT;
            end
          end
          6'b111111: begin
            pc_en      = 1'b0;
            state_next = HALT;
          end
          default: s_inc = 1'b1;
        endcase
      end

      IO_WAIT: begin
        op_alu = op[ALU_W+1:2];
        io_req = 1'b1;
        if (bus.io_ack) begin
          pc_en      = 1'b1;
          s_inc      = 1'b1;
          state_next = FETCH;
          if (op == 6'b100111) begin
            sel_inputs = 2'b01;
            we3        = 1'b1;
          end else begin
            we_port = 1'b1;
          end
        end else if (cnt_q == CNT_LAST) begin
          state_next = HALT;
        end else begin
          cnt_next = cnt_q + 1'b1;
        end
      end

      HALT: trap = 1'b1;

      default: state_next = FETCH;
    endcase

    // The state register clears asynchronously, but FETCH would still show ir_load
    if (!reset) begin
      ir_load    = 1'b0;
      pc_en      = 1'b0;
      s_inc      = 1'b0;
      sel_inputs = 2'b00;
      we3        = 1'b0;
      wez        = 1'b0;
      we_port    = 1'b0;
      we_stack   = 1'b0;
      s_jret     = 1'b0;
      op_alu     = '0;
      io_req     = 1'b0;
      trap       = 1'b0;
    end
  end

  assign bus.ir_load    = ir_load;
  assign bus.pc_en      = pc_en;
  assign bus.s_inc      = s_inc;
  assign bus.sel_inputs = sel_inputs;
  assign bus.we3        = we3;
  assign bus.wez        = wez;
  assign bus.we_port    = we_port;
  assign bus.we_stack   = we_stack;
  assign bus.s_jret     = s_jret;
  assign bus.op_alu     = op_alu;
  assign bus.io_req     = io_req;
  assign bus.depth      = depth_q;
  assign bus.trap       = trap;
endmodule
